// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: capture-session sequencer (start/abort/cfg_* in; trig_rstn/max_rst to ADC; s_axis in, one-deep m_axis out; busy/done/timed_out/overflow/bursts_done/words_fwd status)
module adc_capture_sequencer #(
  parameter int CNT_WIDTH   = 32,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [BURST_WIDTH-1:0] cfg_bursts,
  input  logic [BURST_WIDTH-1:0] cfg_holdoff,
  input  logic [CNT_WIDTH-1:0]   cfg_timeout,
  output logic                   trig_rstn,
  output logic                   max_rst,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic [31:0]            s_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic [31:0]            m_axis_tdata,
  input  logic                   m_axis_tready,
  output logic                   busy,
  output logic                   done,
  output logic                   timed_out,
  output logic                   overflow,
  output logic [BURST_WIDTH-1:0] bursts_done,
  output logic [CNT_WIDTH-1:0]   words_fwd
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ARMED, S_BURST, S_HOLD, S_DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc, timeout_q, words_inc;
  logic [BURST_WIDTH-1:0] bursts_q, holdoff_q, hold_len, bd_inc;
  logic abort_pend_q, go, cap, burst_end, fin, to_hit, ovf_hit;
  always_comb begin
    cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
    words_inc = &words_fwd ? words_fwd : words_fwd + CNT_WIDTH'(1);
    bd_inc = &bursts_done ? bursts_done : bursts_done + BURST_WIDTH'(1);
    hold_len = (holdoff_q == '0) ? BURST_WIDTH'(1) : holdoff_q;
    go = (state_q == S_IDLE) && start && !abort;
    cap = s_axis_tvalid && ((state_q == S_BURST) || ((state_q == S_ARMED) && !abort));
    burst_end = cap && s_axis_tlast;
    fin = ((bursts_q != '0) && (bd_inc == bursts_q)) || abort_pend_q || abort;
    to_hit = (state_q == S_ARMED) && !abort && !cap && (timeout_q != '0) && (cnt_inc == timeout_q);
    ovf_hit = m_axis_tvalid && !m_axis_tready;
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = go ? S_CLEAR : S_IDLE;
      S_CLEAR: state_d = abort ? S_DONE : ((cnt_q == CNT_WIDTH'(1)) ? S_ARMED : S_CLEAR);
      S_ARMED: state_d = (abort || to_hit) ? S_DONE : (!cap ? S_ARMED : (!s_axis_tlast ? S_BURST : (fin ? S_DONE : S_HOLD)));
      S_BURST: state_d = !burst_end ? S_BURST : (fin ? S_DONE : S_HOLD);
      S_HOLD:  state_d = abort ? S_DONE : ((cnt_inc >= CNT_WIDTH'(hold_len)) ? S_ARMED : S_HOLD);
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_inc;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      timeout_q <= '0;
      bursts_q <= '0;
      holdoff_q <= '0;
      abort_pend_q <= 1'b0;
      trig_rstn <= 1'b0;
      max_rst <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      timed_out <= 1'b0;
      overflow <= 1'b0;
      bursts_done <= '0;
      words_fwd <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      trig_rstn <= (state_d == S_ARMED) || (state_d == S_BURST);
      max_rst <= state_d == S_CLEAR;
      busy <= state_d != S_IDLE;
      done <= state_d == S_DONE;
      if (go) begin
        bursts_q <= cfg_bursts;
        holdoff_q <= cfg_holdoff;
        timeout_q <= cfg_timeout;
        abort_pend_q <= 1'b0;
        timed_out <= 1'b0;
        overflow <= 1'b0;
        bursts_done <= '0;
        words_fwd <= '0;
      end
      if ((state_q == S_BURST) && abort) abort_pend_q <= 1'b1;
      if (to_hit) timed_out <= 1'b1;
      if (burst_end) bursts_done <= bd_inc;
      if (cap) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tlast <= s_axis_tlast || (ovf_hit && m_axis_tlast);
        m_axis_tvalid <= 1'b1;
        words_fwd <= words_inc;
        if (ovf_hit) overflow <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule
